router_term_tx: RTL and testbench
=================================

# router_term_tx

Terminal-side packet source for the router mesh: one instance per terminal drives that terminal's router input port. It assembles packets from host requests and buffers them in a first-word-fall-through FIFO. The head packet is presented on `data_out_i_in` with `pndng_i_in`, and is dequeued when the router asserts `popin`. It is the transmit counterpart of the router-output checking already in place, and makes the router's input-side handshake drivable from directed tests and from the agent layer.

## Interface
- `ROWS`, 4, mesh rows; legal destination row range 0..ROWS+1
- `COLUMS`, 4, mesh columns; legal destination column range 0..COLUMS+1
- `PCK_SZ`, 40, packet width; minimum 40
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TIMEOUT`, 128, watchdog limit in cycles
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `push` in 1: host request to enqueue one packet
- `dst_row` in 4: destination row
- `dst_col` in 4: destination column
- `mode` in 1: routing mode bit
- `payload` in PCK_SZ-17: packet payload
- `full` out 1: FIFO holds DEPTH entries
- `count` out $clog2(DEPTH)+1: current occupancy
- `data_out_i_in` out PCK_SZ: head packet to the router
- `pndng_i_in` out 1: head packet valid
- `popin` in 1: router consumes the head packet
- `overflow` out 1: sticky; a push was lost because the FIFO was full
- `bad_dst` out 1: sticky; a push was dropped for an illegal destination
- `stall` out 1: watchdog flag

## Operation
- Packet layout, MSB to LSB:
  - [PCK_SZ-1:PCK_SZ-8]: next-jump field, always driven 0
  - [PCK_SZ-9:PCK_SZ-12]: `dst_row`
  - [PCK_SZ-13:PCK_SZ-16]: `dst_col`
  - [PCK_SZ-17]: `mode`
  - [PCK_SZ-18:0]: `payload`
- Push acceptance requires all of:
  - `push` = 1
  - `dst_row` ≤ ROWS+1 and `dst_col` ≤ COLUMS+1
  - not full, or full with `popin` = 1 in the same cycle
- Illegal destination: the packet is dropped and `bad_dst` is set.
- Push while full without `popin`: the packet is dropped and `overflow` is set.
- Accepted packets are written at the write pointer. Pointers wrap modulo DEPTH.
- `popin` is effective only when `pndng_i_in` = 1. It advances the read pointer. `popin` on an empty FIFO is ignored, with no underflow.
- Simultaneous accepted push and effective pop: `count` is unchanged and both pointers advance.
- `pndng_i_in` = (`count` ≠ 0).
- `data_out_i_in` = the entry at the read pointer when `count` ≠ 0, otherwise all zeros.
- `full` = (`count` == DEPTH).
- Packets are delivered strictly in acceptance order, with no duplication.
- `overflow` and `bad_dst` clear only on `reset`.

## Timing
- Reset values: `count`=0, `full`=0, `pndng_i_in`=0, `data_out_i_in`=0, `overflow`=0, `bad_dst`=0, `stall`=0. Both pointers are 0 and the watchdog counter is 0.
- Push latency: a push accepted at edge N gives `pndng_i_in`=1 after edge N if the FIFO was empty. `data_out_i_in` shows that packet in the same cycle.
- Pop: `popin` sampled at edge N updates the head to the next entry after edge N. If that pop empties the FIFO, `pndng_i_in` drops after edge N.
- Back-to-back `popin` every cycle drains one entry per cycle.
- Sticky flags assert in the cycle after the offending push edge.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. Queued packets are discarded.

## Configuration
- Macro: `ROUTER_TX_WATCHDOG_EN`.
- Defined: the watchdog counter behaves as follows.
  - It increments on every edge with `pndng_i_in`=1 and `popin`=0.
  - It clears on `popin`=1 or when the FIFO is empty.
  - When the counter reaches TIMEOUT, `stall` goes to 1 and stays at 1 until the next effective `popin`. The counter saturates at TIMEOUT.
- Not defined: no counter is built and `stall` is tied to 0.

## Test plan
- Reset, then push packets with `dst_row`=0, `dst_col`=1, `mode`=1 and payloads 0x1..0x3 with `popin` held at 0.
  - Required: `count`=3, `pndng_i_in`=1, head payload 0x1, next-jump field 0.
  - Then `popin` for 3 cycles: payloads 0x1, 0x2, 0x3 in order, then `pndng_i_in`=0 and `data_out_i_in`=0.
- Fill to DEPTH=8, then:
  - push with `popin`=0: dropped, `overflow`=1, `count`=8.
  - push with `popin`=1: accepted, `count` stays 8, order preserved.
- Push with `dst_row`=6 at ROWS=4: dropped, `bad_dst`=1, `count` unchanged. A later legal push is accepted normally.
- Wrap-around: run 20 push/pop pairs through DEPTH=8. All 20 payloads must emerge in order with no loss.
- With `ROUTER_TX_WATCHDOG_EN` defined: enqueue one packet and hold `popin`=0.
  - `stall`=1 after 128 edges.
  - One `popin`: `stall`=0 and `pndng_i_in`=0.
- Assert `reset` with 5 packets queued and the flags set: all outputs read 0 immediately, and the first push afterwards appears at the head.

Source files
------------

// File: rtl/router_term_tx.sv
// router_term_tx: terminal-side packet source for one router input port.
// Host pushes are assembled into packets and queued in a first-word-fall-through
// FIFO; the head packet is offered on data_out_i_in/pndng_i_in and removed when
// the router asserts popin.
// Optional feature macro: ROUTER_TX_WATCHDOG_EN (head-of-line stall watchdog).
module router_term_tx #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLUMS  = 4,
  parameter int unsigned PCK_SZ  = 40,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [3:0]                 dst_row,
  input  logic [3:0]                 dst_col,
  input  logic                       mode,
  input  logic [PCK_SZ-18:0]         payload,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [PCK_SZ-1:0]          data_out_i_in,
  output logic                       pndng_i_in,
  input  logic                       popin,
  output logic                       overflow,
  output logic                       bad_dst,
  output logic                       stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Reject parameter sets the packet layout or pointer arithmetic cannot support.
  if (PCK_SZ < 40 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("router_term_tx: illegal parameter set");
  end

  logic [PCK_SZ-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [PCK_SZ-1:0] packet;
  logic              dst_legal;
  logic              accept;
  logic              pop_eff;
  logic              is_empty;
  logic              is_full;
  logic [CW-1:0]     count_next;

  // Packet assembly: next-jump byte is always zero on injection.
  always_comb begin
    packet = {8'h00, dst_row, dst_col, mode, payload};
  end

  // Acceptance and effective-pop qualification.
  always_comb begin
    is_empty  = (count_q == '0);
    is_full   = (count_q == DEPTH_C);
    dst_legal = (32'(dst_row) <= ROWS + 1) && (32'(dst_col) <= COLUMS + 1);
    pop_eff   = popin && !is_empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    accept    = push && dst_legal && (!is_full || popin);
  end

  // Occupancy update for push/pop combinations.
  always_comb begin
    count_next = count_q;
    unique case ({accept, pop_eff})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  // Pointer, occupancy and sticky-flag state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
      bad_dst  <= 1'b0;
    end else begin
      count_q <= count_next;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !dst_legal) begin
        bad_dst <= 1'b1;
      end
      if (push && dst_legal && is_full && !popin) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array; contents need no reset because the output is gated by occupancy.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= packet;
    end
  end

  // Fall-through head presentation.
  always_comb begin
    count         = count_q;
    full          = is_full;
    pndng_i_in    = !is_empty;
    data_out_i_in = is_empty ? '0 : mem[rd_ptr];
  end

`ifdef ROUTER_TX_WATCHDOG_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  logic [WW-1:0] wd_cnt;

  // Counts cycles the head waits unconsumed; saturates at TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (popin || is_empty) begin
      wd_cnt <= '0;
    end else if (wd_cnt != TIMEOUT_C) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Stall holds while the counter sits at its limit; only a pop clears it.
  always_comb begin
    stall = (wd_cnt == TIMEOUT_C);
  end
`else
  // Watchdog not built.
  always_comb begin
    stall = 1'b0;
  end
`endif

endmodule

// File: tb/tb_router_term_tx.sv
// Directed self-checking bench for router_term_tx.
module tb_router_term_tx;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLUMS  = 4;
  localparam int unsigned PCK_SZ  = 40;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 128;
  localparam int unsigned PW      = PCK_SZ - 17;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic [3:0]        dst_row;
  logic [3:0]        dst_col;
  logic              mode;
  logic [PW-1:0]     payload;
  logic              full;
  logic [CW-1:0]     count;
  logic [PCK_SZ-1:0] data_out_i_in;
  logic              pndng_i_in;
  logic              popin;
  logic              overflow;
  logic              bad_dst;
  logic              stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_term_tx #(
    .ROWS   (ROWS),
    .COLUMS (COLUMS),
    .PCK_SZ (PCK_SZ),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .dst_row      (dst_row),
    .dst_col      (dst_col),
    .mode         (mode),
    .payload      (payload),
    .full         (full),
    .count        (count),
    .data_out_i_in(data_out_i_in),
    .pndng_i_in   (pndng_i_in),
    .popin        (popin),
    .overflow     (overflow),
    .bad_dst      (bad_dst),
    .stall        (stall)
  );

  function automatic logic [PCK_SZ-1:0] pkt(input logic [3:0] r, input logic [3:0] c,
                                            input logic m, input logic [PW-1:0] p);
    return {8'h00, r, c, m, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic p, input logic [3:0] r, input logic [3:0] c,
                      input logic m, input logic [PW-1:0] pl, input logic pop);
    push    = p;
    dst_row = r;
    dst_col = c;
    mode    = m;
    payload = pl;
    popin   = pop;
    @(posedge clk);
    #1;
    push  = 1'b0;
    popin = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_pndng"}, 64'(pndng_i_in), 64'd0);
    chk({tag, "_data"}, 64'(data_out_i_in), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_bad"}, 64'(bad_dst), 64'd0);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    logic [PW-1:0] expp;
    reset   = 1'b0;
    push    = 1'b0;
    popin   = 1'b0;
    dst_row = '0;
    dst_col = '0;
    mode    = 1'b0;
    payload = '0;

    // Reset state, asynchronously before any clock edge.
    #1 reset = 1'b1;
    #1 chk_all_zero("rst");
    #1 reset = 1'b0;

    // Three pushes to row 0 / col 1 / mode 1, no pops.
    for (int i = 1; i <= 3; i++) step(1'b1, 4'd0, 4'd1, 1'b1, PW'(i), 1'b0);
    chk("basic_count", 64'(count), 64'd3);
    chk("basic_pndng", 64'(pndng_i_in), 64'd1);
    chk("basic_head", 64'(data_out_i_in), 64'(pkt(4'd0, 4'd1, 1'b1, 23'h1)));
    chk("basic_nj", 64'(data_out_i_in[PCK_SZ-1:PCK_SZ-8]), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("drain_head", 64'(data_out_i_in), 64'(pkt(4'd0, 4'd1, 1'b1, PW'(i))));
      step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    end
    chk("drain_pndng", 64'(pndng_i_in), 64'd0);
    chk("drain_data", 64'(data_out_i_in), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    // Pop on empty is ignored.
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    chk("underflow_count", 64'(count), 64'd0);

    // Fill to DEPTH with varied legal headers.
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'(i % 6), 4'(5 - (i % 6)), i[0], PW'(32'h10 + i), 1'b0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ovf0", 64'(overflow), 64'd0);
    chk("fill_head", 64'(data_out_i_in), 64'(pkt(4'd0, 4'd5, 1'b0, 23'h10)));

    // Push while full without pop is dropped.
    step(1'b1, 4'd1, 4'd1, 1'b0, 23'h99, 1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd8);

    // Push while full with pop is accepted.
    step(1'b1, 4'd2, 4'd3, 1'b1, 23'h20, 1'b1);
    chk("fullpp_count", 64'(count), 64'd8);
    chk("fullpp_full", 64'(full), 64'd1);
    for (int i = 1; i < 8; i++) begin
      chk("fullpp_order", 64'(data_out_i_in),
          64'(pkt(4'(i % 6), 4'(5 - (i % 6)), i[0], PW'(32'h10 + i))));
      step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    end
    chk("fullpp_last", 64'(data_out_i_in), 64'(pkt(4'd2, 4'd3, 1'b1, 23'h20)));
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    chk("fullpp_empty", 64'(count), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Illegal destination row 6 is dropped.
    chk("bad_before", 64'(bad_dst), 64'd0);
    step(1'b1, 4'd6, 4'd1, 1'b0, 23'h66, 1'b0);
    chk("bad_flag", 64'(bad_dst), 64'd1);
    chk("bad_count", 64'(count), 64'd0);
    chk("bad_pndng", 64'(pndng_i_in), 64'd0);
    // Illegal column 6 with a legal row is also dropped.
    step(1'b1, 4'd1, 4'd6, 1'b0, 23'h67, 1'b0);
    chk("badcol_count", 64'(count), 64'd0);
    // Edge-of-range destination 5/5 is legal.
    step(1'b1, 4'd5, 4'd5, 1'b0, 23'h55, 1'b0);
    chk("edge_count", 64'(count), 64'd1);
    chk("edge_head", 64'(data_out_i_in), 64'(pkt(4'd5, 4'd5, 1'b0, 23'h55)));
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    chk("edge_empty", 64'(count), 64'd0);

    // Wrap-around: 20 payloads through simultaneous push/pop.
    step(1'b1, 4'd3, 4'd2, 1'b0, 23'h100, 1'b0);
    for (int i = 1; i < 20; i++) begin
      expp = PW'(32'h100 + i - 1);
      chk("wrap_head", 64'(data_out_i_in), 64'(pkt(4'd3, 4'd2, 1'b0, expp)));
      step(1'b1, 4'd3, 4'd2, 1'b0, PW'(32'h100 + i), 1'b1);
      chk("wrap_count", 64'(count), 64'd1);
    end
    chk("wrap_tail", 64'(data_out_i_in), 64'(pkt(4'd3, 4'd2, 1'b0, 23'h113)));
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    chk("wrap_empty", 64'(pndng_i_in), 64'd0);

    // Watchdog.
    step(1'b1, 4'd1, 4'd2, 1'b1, 23'h42, 1'b0);
`ifdef ROUTER_TX_WATCHDOG_EN
    for (int i = 0; i < 127; i++) idle();
    chk("wd_pre", 64'(stall), 64'd0);
    idle();
    chk("wd_stall", 64'(stall), 64'd1);
    for (int i = 0; i < 5; i++) idle();
    chk("wd_hold", 64'(stall), 64'd1);
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    chk("wd_clear", 64'(stall), 64'd0);
    chk("wd_pndng", 64'(pndng_i_in), 64'd0);
`else
    for (int i = 0; i < 140; i++) idle();
    chk("wd_off", 64'(stall), 64'd0);
    step(1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1);
    chk("wd_off_pndng", 64'(pndng_i_in), 64'd0);
`endif

    // Mid-operation reset with 5 queued packets and both sticky flags set.
    for (int i = 0; i < 5; i++) step(1'b1, 4'd4, 4'd4, 1'b0, PW'(32'h200 + i), 1'b0);
    chk("pre_rst_count", 64'(count), 64'd5);
    chk("pre_rst_flags", 64'({overflow, bad_dst}), 64'h3);
    #2 reset = 1'b1;
    #1 chk_all_zero("midrst");
    #1 reset = 1'b0;
    step(1'b1, 4'd2, 4'd2, 1'b1, 23'h77, 1'b0);
    chk("post_rst_count", 64'(count), 64'd1);
    chk("post_rst_head", 64'(data_out_i_in), 64'(pkt(4'd2, 4'd2, 1'b1, 23'h77)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
